// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants, grant encoding and arbitration rule for the register-file write-port arbiter.
// The optional statistics counters are enabled with WB_ARB_STATS_EN (see wb_write_arbiter.sv).

// Width of the packed {rf_we, rf_wregno, rf_wdata, csr_we, csr_wcsrno, csr_wdata} WB->DE bus.
`define WBA_FROM_WB_TO_DE_W (1 + 5 + 32 + 1 + 12 + 32)

package wb_write_arbiter_pkg;

  localparam int WBA_DBITS     = 32;
  localparam int WBA_REGNOBITS = 5;
  localparam int WBA_REGWORDS  = 32;
  localparam int WBA_CSRNOBITS = 12;
  localparam int WBA_LL_DEPTH  = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LL   = 2'd2
  } grant_e;

  // Pipe has priority unless the FIFO head has waited its limit or the FIFO is full.
  function automatic grant_e wba_arbitrate(input logic pipe_req,
                                           input logic fifo_empty,
                                           input logic fifo_full,
                                           input logic starved);
    if (fifo_empty) begin
      return pipe_req ? GNT_PIPE : GNT_NONE;
    end
    if (!pipe_req || starved || fifo_full) begin
      return GNT_LL;
    end
    return GNT_PIPE;
  endfunction

endpackage

// File: rtl/wb_ll_fifo.sv
// In-order buffer for long-latency results; also reports the set of destination
// registers held by valid entries so decode can interlock on them.
module wb_ll_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH     = WBA_LL_DEPTH,
  parameter int DBITS     = WBA_DBITS,
  parameter int REGNOBITS = WBA_REGNOBITS,
  parameter int REGWORDS  = WBA_REGWORDS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [REGNOBITS-1:0]     push_regno_i,
  input  logic [DBITS-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [REGNOBITS-1:0]     head_regno_o,
  output logic [DBITS-1:0]         head_data_o,
  output logic [REGWORDS-1:0]      dest_mask_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic [REGNOBITS-1:0] regno_q [DEPTH];
  logic [DBITS-1:0]     data_q  [DEPTH];
  logic                 do_push;
  logic                 do_pop;
  logic [AW-1:0]        slot;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_regno_o = regno_q[rd_ptr_q[AW-1:0]];
  assign head_data_o  = data_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      regno_q[wr_ptr_q[AW-1:0]] <= push_regno_i;
      data_q[wr_ptr_q[AW-1:0]]  <= push_data_i;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    dest_mask_o = '0;
    slot        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = AW'(i) - rd_ptr_q[AW-1:0];
      if ({1'b0, slot} < count_o) begin
        dest_mask_o[regno_q[i]] = 1'b1;
      end
    end
    dest_mask_o[0] = 1'b0;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered long-latency results.
// Define WB_ARB_STATS_EN to add the conflict / forced-grant statistics counters.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DBITS     = WBA_DBITS,
  parameter int REGNOBITS = WBA_REGNOBITS,
  parameter int REGWORDS  = WBA_REGWORDS,
  parameter int CSRNOBITS = WBA_CSRNOBITS,
  parameter int LL_DEPTH  = WBA_LL_DEPTH,
  parameter int MAX_WAIT  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pipe_wr_reg_i,
  input  logic [REGNOBITS-1:0]        pipe_wregno_i,
  input  logic [DBITS-1:0]            pipe_regval_i,
  input  logic                        pipe_wr_csr_i,
  input  logic [CSRNOBITS-1:0]        pipe_wcsrno_i,
  output logic                        pipe_stall_o,
  input  logic                        ll_valid_i,
  output logic                        ll_ready_o,
  input  logic [REGNOBITS-1:0]        ll_wregno_i,
  input  logic [DBITS-1:0]            ll_regval_i,
  output logic [REGWORDS-1:0]         ll_pending_o,
  output logic [$clog2(LL_DEPTH):0]   fifo_count_o,
  output logic                        rf_we_o,
  output logic [REGNOBITS-1:0]        rf_wregno_o,
  output logic [DBITS-1:0]            rf_wdata_o,
  output logic                        csr_we_o,
  output logic [CSRNOBITS-1:0]        csr_wcsrno_o,
  output logic [DBITS-1:0]            csr_wdata_o
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_conflicts_o,
  output logic [31:0]                 stat_forced_o
`endif
);

  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);
  localparam logic [SW-1:0] SW_ONE     = 1;

  logic                 pipe_req;
  logic                 ll_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [REGNOBITS-1:0] head_regno;
  logic [DBITS-1:0]     head_data;
  grant_e               grant;
  logic                 ll_pop;
  logic                 starved;

  logic [SW-1:0]        starve_q, starve_d;
  logic                 rf_we_q, rf_we_d;
  logic [REGNOBITS-1:0] rf_wregno_q, rf_wregno_d;
  logic [DBITS-1:0]     rf_wdata_q, rf_wdata_d;
  logic                 csr_we_q, csr_we_d;
  logic [CSRNOBITS-1:0] csr_wcsrno_q, csr_wcsrno_d;
  logic [DBITS-1:0]     csr_wdata_q, csr_wdata_d;

  // x0 never consumes the write port, from either source.
  assign pipe_req   = pipe_wr_reg_i && (pipe_wregno_i != '0);
  assign ll_ready_o = !fifo_full && !reset;
  assign ll_push    = ll_valid_i && ll_ready_o && (ll_wregno_i != '0);

  wb_ll_fifo #(
    .DEPTH     (LL_DEPTH),
    .DBITS     (DBITS),
    .REGNOBITS (REGNOBITS),
    .REGWORDS  (REGWORDS)
  ) u_ll_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (ll_push),
    .push_regno_i (ll_wregno_i),
    .push_data_i  (ll_regval_i),
    .pop_i        (ll_pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count_o),
    .head_regno_o (head_regno),
    .head_data_o  (head_data),
    .dest_mask_o  (ll_pending_o)
  );

  assign starved      = (starve_q == MAX_WAIT_C);
  assign grant        = wba_arbitrate(pipe_req, fifo_empty, fifo_full, starved);
  assign ll_pop       = (grant == GNT_LL);
  assign pipe_stall_o = pipe_req && (grant == GNT_LL);

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || (grant == GNT_LL)) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SW_ONE;
    end
  end

  // Write-port stage: data fields hold when nothing is granted.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_wregno_d = rf_wregno_q;
    rf_wdata_d  = rf_wdata_q;
    case (grant)
      GNT_PIPE: begin
        rf_we_d     = 1'b1;
        rf_wregno_d = pipe_wregno_i;
        rf_wdata_d  = pipe_regval_i;
      end
      GNT_LL: begin
        rf_we_d     = 1'b1;
        rf_wregno_d = head_regno;
        rf_wdata_d  = head_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    csr_we_d     = pipe_wr_csr_i && !pipe_stall_o;
    csr_wcsrno_d = csr_wcsrno_q;
    csr_wdata_d  = csr_wdata_q;
    if (csr_we_d) begin
      csr_wcsrno_d = pipe_wcsrno_i;
      csr_wdata_d  = pipe_regval_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q     <= '0;
      rf_we_q      <= 1'b0;
      rf_wregno_q  <= '0;
      rf_wdata_q   <= '0;
      csr_we_q     <= 1'b0;
      csr_wcsrno_q <= '0;
      csr_wdata_q  <= '0;
    end else begin
      starve_q     <= starve_d;
      rf_we_q      <= rf_we_d;
      rf_wregno_q  <= rf_wregno_d;
      rf_wdata_q   <= rf_wdata_d;
      csr_we_q     <= csr_we_d;
      csr_wcsrno_q <= csr_wcsrno_d;
      csr_wdata_q  <= csr_wdata_d;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_wregno_o  = rf_wregno_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign csr_we_o     = csr_we_q;
  assign csr_wcsrno_o = csr_wcsrno_q;
  assign csr_wdata_o  = csr_wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_conflicts_q, stat_conflicts_d;
  logic [31:0] stat_forced_q, stat_forced_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? (v + 32'd1) : v;
  endfunction

  always_comb begin
    stat_conflicts_d = sat_inc(stat_conflicts_q, pipe_req && !fifo_empty);
    stat_forced_d    = sat_inc(stat_forced_q, pipe_req && (grant == GNT_LL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_conflicts_q <= '0;
      stat_forced_q    <= '0;
    end else begin
      stat_conflicts_q <= stat_conflicts_d;
      stat_forced_q    <= stat_forced_d;
    end
  end

  assign stat_conflicts_o = stat_conflicts_q;
  assign stat_forced_o    = stat_forced_q;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: expected writes are queued as stimulus is issued
// and a monitor pops and compares them whenever the DUT asserts a write enable.
module tb_wb_write_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_wr_reg_i;
  logic [4:0]  pipe_wregno_i;
  logic [31:0] pipe_regval_i;
  logic        pipe_wr_csr_i;
  logic [11:0] pipe_wcsrno_i;
  logic        pipe_stall_o;
  logic        ll_valid_i;
  logic        ll_ready_o;
  logic [4:0]  ll_wregno_i;
  logic [31:0] ll_regval_i;
  logic [31:0] ll_pending_o;
  logic [2:0]  fifo_count_o;
  logic        rf_we_o;
  logic [4:0]  rf_wregno_o;
  logic [31:0] rf_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_wcsrno_o;
  logic [31:0] csr_wdata_o;
`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_conflicts_o;
  logic [31:0] stat_forced_o;
`endif

  wb_write_arbiter #(
    .DBITS(32), .REGNOBITS(5), .REGWORDS(32), .CSRNOBITS(12), .LL_DEPTH(4), .MAX_WAIT(3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pipe_wr_reg_i (pipe_wr_reg_i),
    .pipe_wregno_i (pipe_wregno_i),
    .pipe_regval_i (pipe_regval_i),
    .pipe_wr_csr_i (pipe_wr_csr_i),
    .pipe_wcsrno_i (pipe_wcsrno_i),
    .pipe_stall_o  (pipe_stall_o),
    .ll_valid_i    (ll_valid_i),
    .ll_ready_o    (ll_ready_o),
    .ll_wregno_i   (ll_wregno_i),
    .ll_regval_i   (ll_regval_i),
    .ll_pending_o  (ll_pending_o),
    .fifo_count_o  (fifo_count_o),
    .rf_we_o       (rf_we_o),
    .rf_wregno_o   (rf_wregno_o),
    .rf_wdata_o    (rf_wdata_o),
    .csr_we_o      (csr_we_o),
    .csr_wcsrno_o  (csr_wcsrno_o),
    .csr_wdata_o   (csr_wdata_o)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_conflicts_o (stat_conflicts_o),
    .stat_forced_o    (stat_forced_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  regno;
    logic [31:0] data;
  } rf_exp_t;

  typedef struct packed {
    logic [11:0] csrno;
    logic [31:0] data;
  } csr_exp_t;

  rf_exp_t  rf_q[$];
  csr_exp_t csr_q[$];
  rf_exp_t  mon_rf;
  csr_exp_t mon_csr;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_rf(input logic [4:0] r, input logic [31:0] d);
    rf_q.push_back('{regno: r, data: d});
  endtask

  task automatic idle_inputs();
    pipe_wr_reg_i = 1'b0; pipe_wregno_i = '0; pipe_regval_i = '0;
    pipe_wr_csr_i = 1'b0; pipe_wcsrno_i = '0;
    ll_valid_i = 1'b0; ll_wregno_i = '0; ll_regval_i = '0;
  endtask

  task automatic pipe_wr(input logic [4:0] r, input logic [31:0] d);
    pipe_wr_reg_i = 1'b1; pipe_wregno_i = r; pipe_regval_i = d;
  endtask

  task automatic ll_wr(input logic [4:0] r, input logic [31:0] d);
    ll_valid_i = 1'b1; ll_wregno_i = r; ll_regval_i = d;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every write the DUT presents must match the queue head.
  always @(negedge clk) begin
    if (rf_we_o === 1'b1) begin
      if (rf_q.size() == 0) begin
        n_checks++;
        $display("FAIL rf_unexpected: got r%0d=0x%0h, expected no write", rf_wregno_o, rf_wdata_o);
      end else begin
        mon_rf = rf_q.pop_front();
        chk("rf_write", 64'({rf_wregno_o, rf_wdata_o}), 64'({mon_rf.regno, mon_rf.data}));
      end
    end
    if (csr_we_o === 1'b1) begin
      if (csr_q.size() == 0) begin
        n_checks++;
        $display("FAIL csr_unexpected: got csr 0x%0h=0x%0h, expected no write", csr_wcsrno_o, csr_wdata_o);
      end else begin
        mon_csr = csr_q.pop_front();
        chk("csr_write", 64'({csr_wcsrno_o, csr_wdata_o}), 64'({mon_csr.csrno, mon_csr.data}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();

    // Reset state
    sample(); chk("rst_ll_ready", 64'(ll_ready_o), 64'd0);
    next();   sample();
    next();   reset = 1'b0;
    sample();
    chk("rst_rf_we",   64'(rf_we_o), 64'd0);
    chk("rst_csr_we",  64'(csr_we_o), 64'd0);
    chk("rst_count",   64'(fifo_count_o), 64'd0);
    chk("rst_pending", 64'(ll_pending_o), 64'd0);
    chk("rst_ready",   64'(ll_ready_o), 64'd1);
    next();

    // Pipe only, back to back
    pipe_wr(5'd5, 32'h1234); exp_rf(5'd5, 32'h1234);
    sample(); chk("t1_stall_c0", 64'(pipe_stall_o), 64'd0); next();
    pipe_wr(5'd1, 32'h1); exp_rf(5'd1, 32'h1);
    sample(); chk("t1_we_c1", 64'(rf_we_o), 64'd1); chk("t1_stall_c1", 64'(pipe_stall_o), 64'd0); next();
    pipe_wr(5'd31, 32'hFFFF_FFFF); exp_rf(5'd31, 32'hFFFF_FFFF);
    sample(); chk("t1_stall_c2", 64'(pipe_stall_o), 64'd0); next();
    idle_inputs();
    sample(); next();
    sample(); chk("t1_idle_we", 64'(rf_we_o), 64'd0); chk("t1_hold_data", 64'(rf_wdata_o), 64'hFFFF_FFFF); next();

    // x0 filter on both sources
    pipe_wr(5'd0, 32'hBEEF); ll_wr(5'd0, 32'hCAFE);
    sample(); chk("t2_ready", 64'(ll_ready_o), 64'd1); chk("t2_stall", 64'(pipe_stall_o), 64'd0); next();
    idle_inputs();
    sample(); chk("t2_we", 64'(rf_we_o), 64'd0); chk("t2_count", 64'(fifo_count_o), 64'd0);
    chk("t2_pending", 64'(ll_pending_o), 64'd0); next();

    // Long-latency only
    ll_wr(5'd7, 32'hDEAD); exp_rf(5'd7, 32'hDEAD);
    sample(); chk("t3_count_c0", 64'(fifo_count_o), 64'd0); next();
    idle_inputs();
    sample(); chk("t3_pending_c1", 64'(ll_pending_o), 64'h80); chk("t3_count_c1", 64'(fifo_count_o), 64'd1);
    chk("t3_we_c1", 64'(rf_we_o), 64'd0); next();
    sample(); chk("t3_pending_c2", 64'(ll_pending_o), 64'd0); chk("t3_count_c2", 64'(fifo_count_o), 64'd0);
    chk("t3_we_c2", 64'(rf_we_o), 64'd1); next();

    // Starvation: r3 waits three pipe grants, then forces a stall
    ll_wr(5'd3, 32'h33); pipe_wr(5'd10, 32'hA0); exp_rf(5'd10, 32'hA0);
    sample(); chk("t4_stall_c0", 64'(pipe_stall_o), 64'd0); next();
    ll_valid_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      pipe_wr(5'(10 + i), 32'hA0 + 32'(i)); exp_rf(5'(10 + i), 32'hA0 + 32'(i));
      sample(); chk($sformatf("t4_stall_c%0d", i), 64'(pipe_stall_o), 64'd0); next();
    end
    pipe_wr(5'd14, 32'hA4); exp_rf(5'd3, 32'h33);
    sample(); chk("t4_stall_c4", 64'(pipe_stall_o), 64'd1); next();
    exp_rf(5'd14, 32'hA4);
    sample(); chk("t4_stall_c5", 64'(pipe_stall_o), 64'd0); chk("t4_count_c5", 64'(fifo_count_o), 64'd0); next();
    idle_inputs();
    sample(); next();

    // Full FIFO forces a grant; the stalled CSR write follows the unstall
    for (int i = 0; i < 4; i++) begin
      pipe_wr(5'(20 + i), 32'h200 + 32'(i)); exp_rf(5'(20 + i), 32'h200 + 32'(i));
      ll_wr(5'(8 + i), 32'h80 + 32'(i));
      sample(); chk($sformatf("t5_stall_c%0d", i), 64'(pipe_stall_o), 64'd0);
      chk($sformatf("t5_ready_c%0d", i), 64'(ll_ready_o), 64'd1); next();
    end
    ll_valid_i = 1'b0;
    pipe_wr(5'd24, 32'h2400); pipe_wr_csr_i = 1'b1; pipe_wcsrno_i = 12'h300;
    exp_rf(5'd8, 32'h80);
    sample(); chk("t5_ready_full", 64'(ll_ready_o), 64'd0); chk("t5_count_full", 64'(fifo_count_o), 64'd4);
    chk("t5_stall_full", 64'(pipe_stall_o), 64'd1); chk("t5_pending_full", 64'(ll_pending_o), 64'h0F00); next();
    exp_rf(5'd24, 32'h2400); csr_q.push_back('{csrno: 12'h300, data: 32'h2400});
    sample(); chk("t5_stall_c5", 64'(pipe_stall_o), 64'd0); chk("t5_csr_we_c5", 64'(csr_we_o), 64'd0);
    chk("t5_count_c5", 64'(fifo_count_o), 64'd3); next();
    idle_inputs(); exp_rf(5'd9, 32'h81);
    sample(); chk("t5_csr_we_c6", 64'(csr_we_o), 64'd1); next();
    exp_rf(5'd10, 32'h82);
    sample(); next();
    exp_rf(5'd11, 32'h83);
    sample(); next();
    sample(); chk("t5_count_drained", 64'(fifo_count_o), 64'd0); next();

    // Reset in the middle of a drain discards queued entries
    for (int i = 0; i < 3; i++) begin
      pipe_wr(5'(25 + i), 32'h250 + 32'(i)); exp_rf(5'(25 + i), 32'h250 + 32'(i));
      ll_wr(5'(4 + i), 32'h40 + 32'(i));
      sample(); chk($sformatf("t6_stall_c%0d", i), 64'(pipe_stall_o), 64'd0); next();
    end
    idle_inputs(); reset = 1'b1;
    sample(); chk("t6_ready_rst", 64'(ll_ready_o), 64'd0); chk("t6_count_pre", 64'(fifo_count_o), 64'd3);
    chk("t6_pending_pre", 64'(ll_pending_o), 64'h70); next();
    reset = 1'b0;
    sample(); chk("t6_count", 64'(fifo_count_o), 64'd0); chk("t6_pending", 64'(ll_pending_o), 64'd0);
    chk("t6_rf_we", 64'(rf_we_o), 64'd0); chk("t6_ready", 64'(ll_ready_o), 64'd1); next();
    sample(); chk("t6_rf_we_after", 64'(rf_we_o), 64'd0); next();
    sample(); next();

    chk("rf_queue_empty", 64'(rf_q.size()), 64'd0);
    chk("csr_queue_empty", 64'(csr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback and a long-latency unit (mul/div) that returns results out of band. Sits between the WB stage and the DE-stage register file.
- Buffers long-latency results in a small FIFO.
- Arbitrates with pipe priority plus a starvation bound.
- Back-pressures the pipe with a stall.
- Exports a pending-destination mask so DE can interlock on those registers.

Parameters:
DBITS, 32, data width
REGNOBITS, 5, register number width
REGWORDS, 32, number of architectural registers
CSRNOBITS, 12, CSR number width
LL_DEPTH, 4, long-latency FIFO depth (power of 2, >=2)
MAX_WAIT, 3, max cycles a non-empty FIFO head waits before forced grant (>=1)

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
pipe_wr_reg_i  in  1  pipe requests register write
pipe_wregno_i  in  REGNOBITS  pipe destination register
pipe_regval_i  in  DBITS  pipe write data
pipe_wr_csr_i  in  1  pipe requests CSR write
pipe_wcsrno_i  in  CSRNOBITS  pipe CSR number
pipe_stall_o  out  1  pipe must hold its WB instruction this cycle
ll_valid_i  in  1  long-latency result valid
ll_ready_o  out  1  FIFO can accept
ll_wregno_i  in  REGNOBITS  long-latency destination register
ll_regval_i  in  DBITS  long-latency data
ll_pending_o  out  REGWORDS  bit r set if any FIFO entry targets register r
fifo_count_o  out  $clog2(LL_DEPTH)+1  FIFO occupancy
rf_we_o  out  1  register-file write enable (registered)
rf_wregno_o  out  REGNOBITS  write register number
rf_wdata_o  out  DBITS  write data
csr_we_o  out  1  CSR write enable (registered)
csr_wcsrno_o  out  CSRNOBITS  CSR number
csr_wdata_o  out  DBITS  CSR data (= pipe_regval_i)

Behaviour:
- Reset: FIFO empty, starve_cnt=0, all registered outputs 0. ll_ready_o=0 while reset is high. ll_pending_o=0 and fifo_count_o=0 from the next cycle. Reset mid-operation discards FIFO contents.
- pipe_req = pipe_wr_reg_i && pipe_wregno_i!=0. Writes to x0 never consume the port.
- ll_ready_o = !full && !reset. A push occurs when ll_valid_i && ll_ready_o.
- Long-latency results to x0 are accepted and dropped, with no push.
- Push and pop in the same cycle leave the count unchanged. There is no push while full.
- Grant is decided combinationally each cycle from registered FIFO state and starve_cnt:
  - FIFO empty: grant pipe if pipe_req.
  - FIFO non-empty and !pipe_req: grant FIFO head (pop).
  - Both requesting: grant FIFO head if starve_cnt==MAX_WAIT or FIFO full, otherwise grant pipe.
- pipe_stall_o = pipe_req && FIFO granted. The pipe holds all pipe_* inputs stable while stalled.
- CSR writes use a separate port and are never arbitrated. csr_we_o is set next cycle only if pipe_wr_csr_i && !pipe_stall_o.
- starve_cnt: reset to 0 on head grant or empty FIFO. Otherwise increments on each cycle the FIFO is non-empty and ungranted, saturating at MAX_WAIT.
- Output latency is 1 cycle: grant in cycle N gives rf_* in cycle N+1. With no grant, rf_we_o=0 and the data fields hold their previous values.
- The FIFO drains strictly in order.
- ll_pending_o is combinational over valid entries, bit 0 always 0. It drops the cycle after the pop of an entry's grant. WAW ordering between the pipe and the long-latency unit is DE's duty, enforced via ll_pending_o.

Optional Feature:
WB_ARB_STATS_EN defined:
- Adds stat_conflicts_o (32b): cycles with both requesting.
- Adds stat_forced_o (32b): forced FIFO grants due to starvation or full.
- Both reset to 0 and saturate at all-ones.
Undefined: ports and counters absent, no other behaviour change.

Decomposition:
- Shared header constants: DBITS, REGNOBITS, REGWORDS, CSRNOBITS, and LL_DEPTH default. Add the width `define for a packed bus {rf_we, rf_wregno, rf_wdata, csr_we, csr_wcsrno, csr_wdata} matching the from_WB_to_DE layout.
- One sub-module, wb_ll_fifo: parameterised sync FIFO with push/pop/full/empty/count and a per-entry destination-mask output.

Test Plan:
- Pipe only: write r5=0x1234 in cycle 0 -> rf_we_o=1, r5, 0x1234 in cycle 1. pipe_stall_o never high.
- x0 filter: pipe write x0 and ll push x0 -> rf_we_o stays 0. fifo_count_o stays 0.
- LL only: push r7=0xDEAD at cycle 0 -> ll_pending_o[7]=1 in cycle 1, rf write r7 in cycle 2, ll_pending_o[7]=0 in cycle 2.
- Starvation: FIFO holds r3, pipe writes continuously, MAX_WAIT=3 -> pipe wins 3 cycles, then stall in cycle 4 and r3 written in cycle 5.
- Full: 4 pushes with the pipe busy -> ll_ready_o=0 and an immediate forced grant with the pipe stalled. A stalled CSR write (csr 0x300) is delayed to the unstall cycle + 1.
- Reset mid-drain: 3 entries queued, reset pulse -> next cycle fifo_count_o=0, ll_pending_o=0, rf_we_o=0, ll_ready_o=1.
